// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: pointer/level widths and the wrapping pointer increment.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps at depth-1 so non-power-of-two depths are handled without modulo hardware.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_ptr.sv
// Wrapping FIFO pointer register; clr takes priority over inc.
module fifo_sync_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (clr) begin
      ptr_next = '0;
    end else if (inc) begin
      ptr_next = PTR_W'(ptr_inc(32'(ptr_reg), DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_sync_buf.sv
// Synchronous FIFO with show-ahead output, level count, almost flags and registered error pulses.
module fifo_sync_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       flush,
  input  logic                       wrreq,
  input  logic [DATA_W-1:0]          d,
  input  logic                       rdack,
  output logic [DATA_W-1:0]          q,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       underrun,
  output logic                       overrun,
  output logic                       err
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  if (DEPTH < 2 || AF_LVL > DEPTH || AE_LVL >= DEPTH) begin : g_bad_param
    $error("fifo_sync_buf: illegal DEPTH/AF_LVL/AE_LVL combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [LVL_W-1:0]  level_reg;
  logic [LVL_W-1:0]  level_next;
  logic              underrun_reg;
  logic              overrun_reg;
  logic              err_reg;
  logic              rd_ok;
  logic              wr_ok;
  logic              rd_bad;
  logic              wr_bad;

  // A push into a full FIFO is legal only when the same-cycle pop frees a slot.
  assign rd_ok      = rdack & ~empty & ~flush;
  assign wr_ok      = wrreq & (~full | rd_ok) & ~flush;
  assign rd_bad     = rdack & empty;
  assign wr_bad     = wrreq & ~wr_ok;
  assign level_next = level_reg + LVL_W'(wr_ok) - LVL_W'(rd_ok);

  fifo_sync_ptr #(.DEPTH(DEPTH)) u_head (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (flush),
    .inc     (wr_ok),
    .ptr     (head)
  );

  fifo_sync_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (flush),
    .inc     (rd_ok),
    .ptr     (tail)
  );

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[head] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset || flush) begin
      level_reg    <= '0;
      underrun_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      level_reg    <= level_next;
      underrun_reg <= rd_bad;
      overrun_reg  <= wr_bad;
      err_reg      <= err_reg | rd_bad | wr_bad;
    end
  end

  assign q            = mem[tail];
  assign level        = level_reg;
  assign empty        = (level_reg == '0);
  assign full         = (level_reg == LVL_W'(DEPTH));
  assign almost_empty = (int'(level_reg) <= AE_LVL);
  assign almost_full  = (int'(level_reg) >= AF_LVL);
  assign underrun     = underrun_reg;
  assign overrun      = overrun_reg;
  assign err          = err_reg;

endmodule
